// File: rtl/color_pkg.sv
// Shared state encoding, default timing constants and a width helper for the
// WS-style serial LED color serializer.
package color_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_LATCH
   } state_t;

   localparam int DEF_N_LEDS = 64;
   localparam int DEF_T_BIT  = 125;
   localparam int DEF_T0H    = 40;
   localparam int DEF_T1H    = 80;
   localparam int DEF_T_RES  = 5000;
   localparam int PIX_BITS   = 24;

   // Width of a counter spanning 0..n-1, never narrower than one bit.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ws_bit_timer.sv
// Per-bit cycle counter and registered high-time compare for the serial data line.
// dout is computed from next-cycle values so it lines up exactly with SEND cycles.
module ws_bit_timer
   import color_pkg::*;
#(
   parameter int T_BIT = DEF_T_BIT,
   parameter int T0H   = DEF_T0H,
   parameter int T1H   = DEF_T1H
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic run,
   input  logic nxt_send,
   input  logic nxt_bit,
   output logic bit_end,
   output logic dout
);

   localparam int CW = cw(T_BIT);
   localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);
   localparam logic [CW-1:0] HI0  = CW'(T0H);
   localparam logic [CW-1:0] HI1  = CW'(T1H);

   logic [CW-1:0] cnt, cnt_nxt;

   assign bit_end = run && (cnt == LAST);

   always_comb begin
      cnt_nxt = cnt;
      if (clr || bit_end)
         cnt_nxt = '0;
      else if (run)
         cnt_nxt = cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt  <= '0;
         dout <= 1'b0;
      end else begin
         cnt  <= cnt_nxt;
         dout <= nxt_send && (cnt_nxt < (nxt_bit ? HI1 : HI0));
      end
   end

endmodule

// File: rtl/color_serializer.sv
// Frame sequencer: pulls one color per pixel from the generator, shifts it out
// MSB first through the bit timer, then holds the line low for the latch period.
module color_serializer
   import color_pkg::*;
#(
   parameter int N_LEDS = DEF_N_LEDS,
   parameter int T_BIT  = DEF_T_BIT,
   parameter int T0H    = DEF_T0H,
   parameter int T1H    = DEF_T1H,
   parameter int T_RES  = DEF_T_RES
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [23:0] color_in,
   output logic        color_step,
   output logic        dout,
   output logic        busy,
   output logic        frame_done
);

   localparam int PW = cw(N_LEDS);
   localparam int BW = cw(PIX_BITS);
   localparam int LW = cw(T_RES);
   localparam logic [PW-1:0] PIX_LAST = PW'(N_LEDS - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(PIX_BITS - 1);
   localparam logic [LW-1:0] RES_LAST = LW'(T_RES - 1);

   generate
      if (!(T0H < T1H && T1H < T_BIT && N_LEDS >= 1 && T_RES >= 1)) begin : g_bad_timing
         $error("color_serializer: timing parameters require T0H < T1H < T_BIT, N_LEDS >= 1, T_RES >= 1");
      end
   endgenerate

   state_t          state, state_nxt;
   logic [23:0]     sh, sh_nxt;
   logic [BW-1:0]   bit_cnt, bit_cnt_nxt;
   logic [PW-1:0]   pix_cnt, pix_cnt_nxt;
   logic [LW-1:0]   lat_cnt, lat_cnt_nxt;
   logic            bit_end;

   always_comb begin
      state_nxt   = state;
      sh_nxt      = sh;
      bit_cnt_nxt = bit_cnt;
      pix_cnt_nxt = pix_cnt;
      lat_cnt_nxt = lat_cnt;
      color_step  = 1'b0;
      frame_done  = 1'b0;
      unique case (state)
         S_IDLE: begin
            pix_cnt_nxt = '0;
            if (start)
               state_nxt = S_LOAD;
         end
         S_LOAD: begin
            color_step  = 1'b1;
            sh_nxt      = color_in;
            bit_cnt_nxt = '0;
            state_nxt   = S_SEND;
         end
         S_SEND: begin
            if (bit_end) begin
               sh_nxt = {sh[22:0], 1'b0};
               if (bit_cnt != BIT_LAST) begin
                  bit_cnt_nxt = bit_cnt + 1'b1;
               end else if (pix_cnt != PIX_LAST) begin
                  pix_cnt_nxt = pix_cnt + 1'b1;
                  state_nxt   = S_LOAD;
               end else begin
                  lat_cnt_nxt = '0;
                  state_nxt   = S_LATCH;
               end
            end
         end
         S_LATCH: begin
            // frame_done lands in the last latch cycle, which is also the exit cycle
            if (lat_cnt == RES_LAST) begin
               frame_done = 1'b1;
               state_nxt  = S_IDLE;
            end else begin
               lat_cnt_nxt = lat_cnt + 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state != S_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         sh      <= '0;
         bit_cnt <= '0;
         pix_cnt <= '0;
         lat_cnt <= '0;
      end else begin
         state   <= state_nxt;
         sh      <= sh_nxt;
         bit_cnt <= bit_cnt_nxt;
         pix_cnt <= pix_cnt_nxt;
         lat_cnt <= lat_cnt_nxt;
      end
   end

   ws_bit_timer #(
      .T_BIT (T_BIT),
      .T0H   (T0H),
      .T1H   (T1H)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (state == S_LOAD),
      .run      (state == S_SEND),
      .nxt_send (state_nxt == S_SEND),
      .nxt_bit  (sh_nxt[23]),
      .bit_end  (bit_end),
      .dout     (dout)
   );

endmodule

// File: tb/tb_color_serializer.sv
// Directed bench for color_serializer with a small color generator model and a
// cycle-exact waveform model of one frame.
module tb_color_serializer;

   localparam int N_LEDS = 2, T_BIT = 10, T0H = 3, T1H = 7, T_RES = 20;
   localparam int PIX_CYC   = 1 + 24 * T_BIT;
   localparam int FRAME_CYC = N_LEDS * PIX_CYC + T_RES;

   logic        clk = 1'b0;
   logic        reset_n, start;
   logic [23:0] color_in;
   logic        color_step, dout, busy, frame_done;

   int          n_cmp = 0, n_bad = 0, n_step = 0, n_done = 0, gen_idx = 0, d0 = 0;
   logic [23:0] c0, c1;

   color_serializer #(
      .N_LEDS (N_LEDS), .T_BIT (T_BIT), .T0H (T0H), .T1H (T1H), .T_RES (T_RES)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .color_in   (color_in),
      .color_step (color_step),
      .dout       (dout),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] gen_color(input int i);
      case (i % 8)
         0:       return 24'hFF0000;
         1:       return 24'h0F00A5;
         2:       return 24'h00FF81;
         3:       return 24'hA5A5A5;
         4:       return 24'h123456;
         5:       return 24'h800001;
         6:       return 24'h7FFFFE;
         default: return 24'hC3003C;
      endcase
   endfunction

   // {dout, busy, color_step, frame_done} for frame cycle c (1 = first LOAD)
   function automatic logic [3:0] exp_out(input int c, input logic [23:0] p0, input logic [23:0] p1);
      int o, s;
      logic [23:0] col;
      if (c <= N_LEDS * PIX_CYC) begin
         o   = (c - 1) % PIX_CYC;
         col = ((c - 1) / PIX_CYC == 0) ? p0 : p1;
         if (o == 0) return 4'b0110;
         s = o - 1;
         return {((s % T_BIT) < (col[23 - s / T_BIT] ? T1H : T0H)), 3'b100};
      end
      return {3'b010, (c == FRAME_CYC)};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; the generator steps after any edge that saw color_step.
   task automatic tick();
      logic cs;
      cs = color_step;
      @(posedge clk);
      #1;
      if (cs) begin
         gen_idx++;
         color_in = gen_color(gen_idx);
      end
      n_step += int'(color_step);
      n_done += int'(frame_done);
   endtask

   task automatic frame(input string tag, input logic [23:0] p0, input logic [23:0] p1,
                        input bit hold, input int ig_lo, input int ig_hi);
      for (int c = 1; c <= FRAME_CYC; c++) begin
         chk($sformatf("%s c%0d", tag, c), {dout, busy, color_step, frame_done}, exp_out(c, p0, p1));
         start = hold || (c >= ig_lo && c <= ig_hi);
         tick();
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      start    = 1'b0;
      color_in = gen_color(0);
      repeat (3) tick();
      chk("reset outputs", {dout, busy, color_step, frame_done}, 4'b0000);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("idle %0d", i), {dout, busy, color_step, frame_done}, 4'b0000);
      end

      // Frame 1: FF0000 then post-step color; start pulsed mid-SEND is ignored
      c0 = color_in;
      c1 = gen_color(gen_idx + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      frame("f1", c0, c1, 1'b0, 100, 110);
      chk("f1 end idle", {dout, busy, color_step, frame_done}, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("f1 stays idle", {dout, busy, color_step, frame_done}, 4'b0000);
      end
      chk("f1 color_step count", n_step, 2);
      chk("f1 frame_done count", n_done, 1);

      // Frame 2: aborted by reset during pixel 2 bit 5
      c0 = color_in;
      c1 = gen_color(gen_idx + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 1; c < 295; c++) begin
         chk($sformatf("f2 c%0d", c), {dout, busy, color_step, frame_done}, exp_out(c, c0, c1));
         tick();
      end
      chk("f2 pre-reset", {dout, busy, color_step, frame_done}, exp_out(295, c0, c1));
      d0 = n_done;
      #2 reset_n = 1'b0;
      #1;
      chk("async reset mid-frame", {dout, busy, color_step, frame_done}, 4'b0000);
      repeat (3) tick();
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("post-abort idle", {dout, busy, color_step, frame_done}, 4'b0000);
      end
      chk("no frame_done on abort", n_done, d0);

      // Frame 3: fresh frame from pixel 0 after the abort
      c0 = color_in;
      c1 = gen_color(gen_idx + 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      frame("f3", c0, c1, 1'b0, 0, -1);
      chk("f3 end idle", {dout, busy, color_step, frame_done}, 4'b0000);
      chk("f3 frame_done count", n_done, d0 + 1);
      tick();

      // Frames 4 and 5: start held high, back to back with one IDLE cycle between
      c0 = color_in;
      c1 = gen_color(gen_idx + 1);
      start = 1'b1;
      tick();
      frame("f4", c0, c1, 1'b1, 0, -1);
      chk("b2b idle gap", {dout, busy, color_step, frame_done}, 4'b0000);
      c0 = color_in;
      c1 = gen_color(gen_idx + 1);
      tick();
      frame("f5", c0, c1, 1'b1, 0, -1);
      chk("f5 end idle", {dout, busy, color_step, frame_done}, 4'b0000);
      start = 1'b0;
      tick();
      chk("stop after release", {dout, busy, color_step, frame_done}, 4'b0000);
      chk("total color_step", n_step, 10);
      chk("total frame_done", n_done, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
